// File: rtl/conv_relu_pool.sv
// rtl/conv_relu_pool.sv - ReLU, scaling, saturation and 2x2 max / top-left pooling stage
module conv_relu_pool #(
    parameter int IMG_W    = 26,
    parameter int IMG_H    = 26,
    parameter int NCH      = 3,
    parameter int IN_BITS  = 32,
    parameter int OUT_BITS = 12,
    parameter int SHIFT    = 4,
    localparam int HW      = IMG_W / 2,
    localparam int HH      = IMG_H / 2,
    localparam int CW      = (HW > 1) ? $clog2(HW) : 1,
    localparam int RW      = (HH > 1) ? $clog2(HH) : 1,
    localparam int XW      = $clog2(IMG_W),
    localparam int YW      = $clog2(IMG_H)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sync_clr,
    input  logic                     pool_mode,
    input  logic [NCH*IN_BITS-1:0]   in_data,
    input  logic                     in_valid,
    output logic [NCH*OUT_BITS-1:0]  out_data,
    output logic                     out_valid,
    output logic [CW-1:0]            out_col,
    output logic [RW-1:0]            out_row,
    output logic                     frame_done
);

    localparam logic signed [IN_BITS-1:0] SAT_MAX = IN_BITS'((1 << (OUT_BITS - 1)) - 1);

    // Negative and zero inputs clamp to 0; positives are scaled down then saturated.
    function automatic logic [OUT_BITS-1:0] relu_scale(input logic signed [IN_BITS-1:0] v);
        logic signed [IN_BITS-1:0] s;
        s = v >>> SHIFT;
        if (v[IN_BITS-1] || (v == '0)) return '0;
        else if (s > SAT_MAX)          return SAT_MAX[OUT_BITS-1:0];
        else                           return s[OUT_BITS-1:0];
    endfunction

    logic [XW-1:0]             x_q, x_d;
    logic [YW-1:0]             y_q, y_d;
    logic                      mode_q, mode_d;
    logic [NCH*OUT_BITS-1:0]   hold_q, hold_d;
    logic [NCH*OUT_BITS-1:0]   out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic [CW-1:0]             out_col_q, out_col_d;
    logic [RW-1:0]             out_row_q, out_row_d;
    logic                      frame_done_q, frame_done_d;

    logic [NCH*OUT_BITS-1:0]   rowbuf [HW];
    logic [NCH*OUT_BITS-1:0]   act_w, hmax_w, pool_w, buf_rd, buf_wd;
    logic                      buf_we;
    logic [CW-1:0]             xh;
    logic [RW-1:0]             yh;
    logic                      x_last, y_last;

    assign xh     = CW'(x_q >> 1);
    assign yh     = RW'(y_q >> 1);
    assign x_last = (x_q == XW'(IMG_W - 1));
    assign y_last = (y_q == YW'(IMG_H - 1));
    assign buf_rd = rowbuf[xh];
    assign buf_wd = mode_q ? hold_q : hmax_w;

    // Activated values are non-negative, so unsigned compares give the signed max.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [OUT_BITS-1:0] a, h, b, m;
        assign a = relu_scale(in_data[c*IN_BITS +: IN_BITS]);
        assign h = hold_q[c*OUT_BITS +: OUT_BITS];
        assign b = buf_rd[c*OUT_BITS +: OUT_BITS];
        assign m = (a > h) ? a : h;
        assign act_w[c*OUT_BITS +: OUT_BITS]  = a;
        assign hmax_w[c*OUT_BITS +: OUT_BITS] = m;
        assign pool_w[c*OUT_BITS +: OUT_BITS] = (b > m) ? b : m;
    end

    // Raster position, mode latch, horizontal hold and pooled output next-state.
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        mode_d       = mode_q;
        hold_d       = hold_q;
        out_data_d   = out_data_q;
        out_col_d    = out_col_q;
        out_row_d    = out_row_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        buf_we       = 1'b0;
        if (sync_clr) begin
            x_d = '0;
            y_d = '0;
        end else if (in_valid) begin
            x_d = x_last ? '0 : x_q + XW'(1);
            if (x_last) y_d = y_last ? '0 : y_q + YW'(1);
            if ((x_q == '0) && (y_q == '0)) mode_d = pool_mode;
            if (!x_q[0]) begin
                hold_d = act_w;
            end else if (!y_q[0]) begin
                buf_we = 1'b1;
            end else begin
                out_valid_d  = 1'b1;
                out_data_d   = mode_q ? buf_rd : pool_w;
                out_col_d    = xh;
                out_row_d    = yh;
                frame_done_d = (xh == CW'(HW - 1)) && (yh == RW'(HH - 1));
            end
        end
    end

    // Control and output registers; the hold register is reset only for tidiness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            y_q          <= '0;
            mode_q       <= 1'b0;
            hold_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_col_q    <= '0;
            out_row_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            mode_q       <= mode_d;
            hold_q       <= hold_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_col_q    <= out_col_d;
            out_row_q    <= out_row_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Half-width row buffer; every entry is rewritten on the even row before it is read.
    always_ff @(posedge clk) begin
        if (buf_we) rowbuf[xh] <= buf_wd;
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_col    = out_col_q;
    assign out_row    = out_row_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/conv_relu_pool.md
Name: conv_relu_pool

Overview:
- Parametrised activation and pooling stage for the CNN pipeline. It sits directly after a bank of parallel conv_calc engines.
- Takes a raster stream of NCH signed convolution results per pixel and applies ReLU, arithmetic right-shift scaling and saturation to each.
- Then performs true 2x2 max pooling (or legacy top-left subsampling, run-time selectable) with an internal half-width row buffer.
- Emits a pooled raster stream with coordinates and an end-of-frame pulse. Replaces the fixed 3-channel, 26x26, subsample-only pooling of the first layer and is reused for later layers.

Parameters:
- IMG_W, 26, conv output width in pixels (>=2).
- IMG_H, 26, conv output height in pixels (>=2).
- NCH, 3, number of parallel channels.
- IN_BITS, 32, signed width of each input channel.
- OUT_BITS, 12, signed width of each output channel.
- SHIFT, 4, arithmetic right-shift applied to positive values (0..IN_BITS-2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- sync_clr  in  1  synchronous frame restart: zero counters, drop partial window.
- pool_mode  in  1  0 = 2x2 max, 1 = top-left subsample; sampled only at frame start.
- in_data  in  NCH*IN_BITS  channel c at bits [c*IN_BITS +: IN_BITS], signed.
- in_valid  in  1  qualifies in_data; one conv pixel per asserted cycle.
- out_data  out  NCH*OUT_BITS  pooled channel c at [c*OUT_BITS +: OUT_BITS], signed, always >= 0.
- out_valid  out  1  one-cycle pulse per pooled pixel.
- out_col  out  $clog2(IMG_W/2)  pooled column of current output (max(1, ...) width).
- out_row  out  $clog2(IMG_H/2)  pooled row of current output.
- frame_done  out  1  pulses with the last out_valid of a frame.

Behaviour:
- Clock is clk.
- Reset is rst_n, asynchronous and active-low.
- Reset clears out_data, out_valid, out_col, out_row, frame_done, the x/y counters and the latched mode (to 0) to zero. Row buffer contents need no reset, but no output may depend on stale buffer data.
- Activation is per channel, combinational on input:
  - in <= 0 gives 0.
  - Otherwise v = in >>> SHIFT; if v > 2^(OUT_BITS-1)-1, saturate to 2^(OUT_BITS-1)-1.
  - Otherwise v truncated to OUT_BITS.
  - Activation precedes pooling; pooling operates on OUT_BITS values.
- Counters x (0..IMG_W-1) and y (0..IMG_H-1) advance only on in_valid. x wraps to 0 and increments y; at x=IMG_W-1, y=IMG_H-1 both wrap to 0 (next frame).
- pool_mode is latched when in_valid arrives with x=0, y=0. Mid-frame changes are ignored.
- Pooling window = columns 2i,2i+1 and rows 2j,2j+1, with i < IMG_W/2 and j < IMG_H/2 (floor division).
- Odd IMG_W: last column is consumed but never pooled. Odd IMG_H: last row is consumed but never pooled.
- Even row, even col: hold the value in a horizontal register.
- Even row, odd col: write into row buffer[x>>1] either max(hold, current) (mode 0) or hold (mode 1).
- Odd row, even col: hold as above.
- Odd row, odd col (inside pooled region), mode 0: the next cycle drives out_data = max(buffer[x>>1], hold, current).
- Odd row, odd col (inside pooled region), mode 1: the next cycle drives out_data = buffer[x>>1].
- On that output cycle, out_valid=1, out_col=x>>1, out_row=y>>1.
- Latency: exactly 1 clk from the in_valid of the window's bottom-right pixel to out_valid.
- out_data holds its value between pulses.
- in_valid gaps of any length are allowed; state freezes.
- No backpressure: downstream must accept every out_valid.
- frame_done=1 coincides with out_valid for out_col=IMG_W/2-1, out_row=IMG_H/2-1.
- sync_clr has priority over in_valid in the same cycle.
- On sync_clr, counters go to 0 and out_valid, frame_done go to 0 next cycle. The latched mode re-latches on the next (0,0) pixel.
- Reset mid-frame: outputs zero immediately. The first post-reset pixel is treated as (0,0).
- Buffer depth is IMG_W/2 entries x NCH x OUT_BITS (one write port, one read port, same address).

Test Plan:
- Defaults, mode 0, channel c of pixel (x,y) = 16*(y*26+x+1) -> 169 out_valid pulses. Pooled (i,j) = y*26+x+1 at x=2i+1, y=2j+1 (e.g. (0,0)=28, (12,12)=676). frame_done only on the 169th pulse.
- Mode 1, same stimulus -> (0,0)=1, (1,0)=3, (0,1)=53, i.e. top-left values. Toggling pool_mode mid-frame changes nothing until the next frame.
- Activation corners on one channel: -5 -> 0; 15 -> 0; 16 -> 1; 0x0001_0000 -> 2047 (saturated); 32767 -> 2047. Other channels are independent.
- Window with mixed signs {-100, 48, 0, 160} -> pooled 10 (mode 0).
- IMG_W=5, IMG_H=5 -> 4 outputs per frame; column 4 and row 4 values never appear; frame_done on (1,1).
- Random in_valid gaps vs gap-free run -> identical output sequence. sync_clr mid-row followed by a fresh frame -> exactly 169 outputs with correct values. rst_n low for 1 cycle mid-frame -> outputs 0 immediately, next frame correct.
